// File: rtl/dual_port_ram_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package  : dual_port_ram_arb_pkg
// Brief    : Shared constants and helpers for the dual-port RAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package dual_port_ram_arb_pkg;

  localparam logic [0:0] c_ST_IDLE  = 1'b0;
  localparam logic [0:0] c_ST_BURST = 1'b1;

  // Requester-ID width; a single requester still needs one bit to carry an ID.
  function automatic int calc_idw(input int num_req);
    return (num_req <= 2) ? 1 : $clog2(num_req);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dual_port_ram_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin picker with next-pointer calculation.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTRW    = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTRW-1:0]    ptr,
  input  logic               update,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTRW-1:0]    next_ptr
);

  logic            w_found;
  logic [PTRW-1:0] w_idx;
  logic [PTRW-1:0] w_cand;

  // Scan upward from the pointer with wrap; the first valid requester wins.
  always_comb begin
    w_found  = 1'b0;
    w_idx    = '0;
    w_cand   = '0;
    grant    = '0;
    next_ptr = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_cand = PTRW'((int'(ptr) + k) % NUM_REQ);
      if (!w_found && req[w_cand]) begin
        w_found = 1'b1;
        w_idx   = w_cand;
      end
    end
    grant[w_idx] = w_found;
    if (update && w_found) begin
      next_ptr = (w_idx == PTRW'(NUM_REQ - 1)) ? '0 : w_idx + PTRW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/dual_port_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dual_port_ram_arbiter
// Brief    : Round-robin burst read / single-word write arbiter for one RAM.
// Revision : 1.0 - initial release
// ============================================================================
module dual_port_ram_arbiter
  import dual_port_ram_arb_pkg::*;
#(
  parameter  int NUM_REQ   = 2,
  parameter  int RAM_WIDTH = 64,
  parameter  int ADDR_LINE = 6,
  localparam int IDW       = calc_idw(NUM_REQ)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               rd_req_valid,
  output logic [NUM_REQ-1:0]               rd_req_ready,
  input  logic [NUM_REQ*ADDR_LINE-1:0]     rd_req_addr,
  input  logic [NUM_REQ*(ADDR_LINE+1)-1:0] rd_req_len,
  output logic                             rd_rsp_valid,
  output logic [IDW-1:0]                   rd_rsp_id,
  output logic                             rd_rsp_last,
  output logic [RAM_WIDTH-1:0]             rd_rsp_data,
  input  logic [NUM_REQ-1:0]               wr_req_valid,
  output logic [NUM_REQ-1:0]               wr_req_ready,
  input  logic [NUM_REQ*ADDR_LINE-1:0]     wr_req_addr,
  input  logic [NUM_REQ*RAM_WIDTH-1:0]     wr_req_data,
  output logic                             ram_rd_en,
  output logic [ADDR_LINE-1:0]             ram_rd_addr,
  input  logic [RAM_WIDTH-1:0]             ram_rd_data,
  output logic                             ram_wr_en,
  output logic [ADDR_LINE-1:0]             ram_wr_addr,
  output logic [RAM_WIDTH-1:0]             ram_wr_data
);

  localparam int LW = ADDR_LINE + 1;

  logic [0:0]           r_state;
  logic [IDW-1:0]       r_rd_ptr;
  logic [IDW-1:0]       r_wr_ptr;
  logic [ADDR_LINE-1:0] r_base;
  logic [LW-1:0]        r_len;
  logic [LW-1:0]        r_cnt;
  logic [IDW-1:0]       r_id;

  logic [NUM_REQ-1:0]   w_rd_grant;
  logic [NUM_REQ-1:0]   w_wr_grant;
  logic [IDW-1:0]       w_rd_next_ptr;
  logic [IDW-1:0]       w_wr_next_ptr;
  logic                 w_rd_hs;
  logic                 w_last;
  logic [ADDR_LINE-1:0] w_sel_addr;
  logic [LW-1:0]        w_sel_len;
  logic [IDW-1:0]       w_sel_id;
  logic [ADDR_LINE-1:0] w_wsel_addr;
  logic [RAM_WIDTH-1:0] w_wsel_data;

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTRW(IDW)) u_rd_arb (
    .req      (rd_req_valid),
    .ptr      (r_rd_ptr),
    .update   (w_rd_hs),
    .grant    (w_rd_grant),
    .next_ptr (w_rd_next_ptr)
  );

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PTRW(IDW)) u_wr_arb (
    .req      (wr_req_valid),
    .ptr      (r_wr_ptr),
    .update   (!rst),
    .grant    (w_wr_grant),
    .next_ptr (w_wr_next_ptr)
  );

  assign w_rd_hs      = !rst && (r_state == c_ST_IDLE) && (|rd_req_valid);
  assign rd_req_ready = w_rd_grant & {NUM_REQ{!rst && (r_state == c_ST_IDLE)}};
  assign wr_req_ready = w_wr_grant & {NUM_REQ{!rst}};

  // One-hot grants make an OR-style mux sufficient for field selection.
  always_comb begin
    w_sel_addr  = '0;
    w_sel_len   = '0;
    w_sel_id    = '0;
    w_wsel_addr = '0;
    w_wsel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_rd_grant[i]) begin
        w_sel_addr = rd_req_addr[i*ADDR_LINE +: ADDR_LINE];
        w_sel_len  = rd_req_len[i*LW +: LW];
        w_sel_id   = IDW'(i);
      end
      if (w_wr_grant[i]) begin
        w_wsel_addr = wr_req_addr[i*ADDR_LINE +: ADDR_LINE];
        w_wsel_data = wr_req_data[i*RAM_WIDTH +: RAM_WIDTH];
      end
    end
  end

  // Address arithmetic is truncated to ADDR_LINE bits so bursts wrap at the top.
  assign ram_rd_en   = (r_state == c_ST_BURST);
  assign ram_rd_addr = r_base + r_cnt[ADDR_LINE-1:0];
  assign w_last      = (r_state == c_ST_BURST) && (r_cnt == r_len - LW'(1));
  assign rd_rsp_data = ram_rd_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= c_ST_IDLE;
      r_rd_ptr <= '0;
      r_base   <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_id     <= '0;
    end else begin
      r_rd_ptr <= w_rd_next_ptr;
      case (r_state)
        c_ST_IDLE: begin
          if (w_rd_hs) begin
            r_base <= w_sel_addr;
            r_len  <= w_sel_len;
            r_id   <= w_sel_id;
            r_cnt  <= '0;
            if (w_sel_len != '0) begin
              r_state <= c_ST_BURST;
            end
          end
        end
        c_ST_BURST: begin
          if (w_last) begin
            r_cnt   <= '0;
            r_state <= c_ST_IDLE;
          end else begin
            r_cnt <= r_cnt + LW'(1);
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  // The RAM has one cycle of read latency, so the response tags follow by one.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_rsp_valid <= 1'b0;
      rd_rsp_last  <= 1'b0;
      rd_rsp_id    <= '0;
    end else begin
      rd_rsp_valid <= ram_rd_en;
      rd_rsp_last  <= w_last;
      rd_rsp_id    <= r_id;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      ram_wr_en   <= 1'b0;
      ram_wr_addr <= '0;
      ram_wr_data <= '0;
    end else begin
      r_wr_ptr <= w_wr_next_ptr;
      if (|w_wr_grant) begin
        ram_wr_en   <= 1'b1;
        ram_wr_addr <= w_wsel_addr;
        ram_wr_data <= w_wsel_data;
      end else begin
        ram_wr_en <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dual_port_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dual_port_ram_arbiter
// Brief    : Scoreboard bench with a behavioural RAM and arbitration model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dual_port_ram_arbiter;

  localparam int N     = 2;
  localparam int W     = 64;
  localparam int A     = 6;
  localparam int LW    = A + 1;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]    rd_req_valid, rd_req_ready;
  logic [N*A-1:0]  rd_req_addr;
  logic [N*LW-1:0] rd_req_len;
  logic            rd_rsp_valid;
  logic [0:0]      rd_rsp_id;
  logic            rd_rsp_last;
  logic [W-1:0]    rd_rsp_data;
  logic [N-1:0]    wr_req_valid, wr_req_ready;
  logic [N*A-1:0]  wr_req_addr;
  logic [N*W-1:0]  wr_req_data;
  logic            ram_rd_en;
  logic [A-1:0]    ram_rd_addr;
  logic [W-1:0]    ram_rd_data;
  logic            ram_wr_en;
  logic [A-1:0]    ram_wr_addr;
  logic [W-1:0]    ram_wr_data;

  dual_port_ram_arbiter #(.NUM_REQ(N), .RAM_WIDTH(W), .ADDR_LINE(A)) dut (
    .clk          (clk),
    .rst          (rst),
    .rd_req_valid (rd_req_valid),
    .rd_req_ready (rd_req_ready),
    .rd_req_addr  (rd_req_addr),
    .rd_req_len   (rd_req_len),
    .rd_rsp_valid (rd_rsp_valid),
    .rd_rsp_id    (rd_rsp_id),
    .rd_rsp_last  (rd_rsp_last),
    .rd_rsp_data  (rd_rsp_data),
    .wr_req_valid (wr_req_valid),
    .wr_req_ready (wr_req_ready),
    .wr_req_addr  (wr_req_addr),
    .wr_req_data  (wr_req_data),
    .ram_rd_en    (ram_rd_en),
    .ram_rd_addr  (ram_rd_addr),
    .ram_rd_data  (ram_rd_data),
    .ram_wr_en    (ram_wr_en),
    .ram_wr_addr  (ram_wr_addr),
    .ram_wr_data  (ram_wr_data)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: one-cycle read, zero when idle, old data on collision.
  logic [W-1:0] ram [DEPTH];
  always @(posedge clk) begin
    if (ram_wr_en) ram[ram_wr_addr] <= ram_wr_data;
    ram_rd_data <= ram_rd_en ? ram[ram_rd_addr] : '0;
  end

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    int           cyc;
    int           id;
    logic [W-1:0] data;
    bit           last;
  } rsp_t;
  rsp_t sbq[$];

  function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] oh(input int i);
    logic [N-1:0] one;
    one = 1;
    return (i < 0) ? '0 : (one << i);
  endfunction

  // Reference model state
  bit           armed = 0;
  int           m_rptr, m_wptr, m_base, m_len, m_id, m_start;
  bit           m_busy;
  bit           m_wpend;
  logic [A-1:0] m_wa;
  logic [W-1:0] m_wd;
  logic [W-1:0] shadow [DEPTH];

  task automatic model_reset();
    m_rptr = 0; m_wptr = 0; m_busy = 0;
    m_wpend = 0; m_wa = '0; m_wd = '0;
  endtask

  always @(negedge clk) begin
    int   j, r, w, a;
    bit   was_busy;
    rsp_t item;
    if (!armed) begin
      if (rst === 1'b1) begin
        armed = 1;
        model_reset();
      end
    end else begin
      was_busy = m_busy;
      if (m_busy) begin
        j = cyc - m_start;
        a = (m_base + j) % DEPTH;
        chk("ram_rd_en", ram_rd_en, 1);
        chk("ram_rd_addr", ram_rd_addr, a);
        if (!rst) begin
          item.cyc = cyc + 1; item.id = m_id; item.data = shadow[a]; item.last = (j == m_len - 1);
          sbq.push_back(item);
        end
        if (j == m_len - 1) m_busy = 0;
      end else begin
        chk("ram_rd_en", ram_rd_en, 0);
      end
      chk("ram_wr_en", ram_wr_en, m_wpend);
      chk("ram_wr_addr", ram_wr_addr, m_wa);
      chk("ram_wr_data", ram_wr_data, m_wd);
      if (m_wpend) shadow[m_wa] = m_wd;
      w = rst ? -1 : rr_pick(wr_req_valid, m_wptr);
      chk("wr_req_ready", wr_req_ready, oh(w));
      if (rst) begin
        m_wpend = 0; m_wa = '0; m_wd = '0; m_wptr = 0;
      end else if (w >= 0) begin
        m_wpend = 1;
        m_wa    = wr_req_addr[w*A +: A];
        m_wd    = wr_req_data[w*W +: W];
        m_wptr  = (w + 1) % N;
      end else begin
        m_wpend = 0;
      end
      r = (rst || was_busy) ? -1 : rr_pick(rd_req_valid, m_rptr);
      chk("rd_req_ready", rd_req_ready, oh(r));
      if (rst) begin
        m_busy = 0; m_rptr = 0;
      end else if (r >= 0) begin
        m_rptr = (r + 1) % N;
        m_len  = int'(rd_req_len[r*LW +: LW]);
        if (m_len > 0) begin
          m_busy  = 1;
          m_base  = int'(rd_req_addr[r*A +: A]);
          m_id    = r;
          m_start = cyc + 1;
        end
      end
    end
  end

  // Response monitor: pops the scoreboard whenever a word is presented.
  always @(negedge clk) begin
    rsp_t e;
    if (armed) begin
      if (rd_rsp_valid !== 1'b0) begin
        if (sbq.size() == 0 || sbq[0].cyc != cyc) begin
          chk("rd_rsp_valid_unexpected", rd_rsp_valid, 0);
        end else begin
          e = sbq.pop_front();
          chk("rd_rsp_id", rd_rsp_id, e.id);
          chk("rd_rsp_data", rd_rsp_data, e.data);
          chk("rd_rsp_last", rd_rsp_last, e.last);
        end
      end else if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        chk("rd_rsp_valid_missing", rd_rsp_valid, 1);
        e = sbq.pop_front();
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd_set(input int i, input bit v, input int addr, input int len);
    rd_req_valid[i]         = v;
    rd_req_addr[i*A +: A]   = A'(addr);
    rd_req_len[i*LW +: LW]  = LW'(len);
  endtask

  task automatic wr_set(input int i, input bit v, input int addr, input logic [W-1:0] data);
    wr_req_valid[i]        = v;
    wr_req_addr[i*A +: A]  = A'(addr);
    wr_req_data[i*W +: W]  = data;
  endtask

  initial begin
    logic [W-1:0] v;
    rst = 1'b1;
    rd_req_valid = '1; rd_req_addr = '0; rd_req_len = '0;
    wr_req_valid = '1; wr_req_addr = '0; wr_req_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      v = {$urandom, $urandom};
      ram[i] = v;
      shadow[i] = v;
    end
    tick();
    chk("reset_ram_rd_en", ram_rd_en, 0);
    chk("reset_ram_wr_en", ram_wr_en, 0);
    chk("reset_rd_rsp_valid", rd_rsp_valid, 0);
    chk("reset_rd_rsp_last", rd_rsp_last, 0);
    chk("reset_rd_rsp_id", rd_rsp_id, 0);
    chk("reset_ram_rd_addr", ram_rd_addr, 0);
    chk("reset_ram_wr_addr", ram_wr_addr, 0);
    chk("reset_ram_wr_data", ram_wr_data, 0);
    chk("reset_rd_req_ready", rd_req_ready, 0);
    chk("reset_wr_req_ready", wr_req_ready, 0);
    tick(2);
    rst = 1'b0; rd_req_valid = '0; wr_req_valid = '0;
    tick(2);

    // Single burst, then a burst that wraps past the top address
    rd_set(0, 1, 4, 3);  tick(); rd_set(0, 0, 0, 0); tick(6);
    rd_set(0, 1, 62, 4); tick(); rd_set(0, 0, 0, 0); tick(6);

    // Both requesters streaming len=2 bursts
    rd_set(0, 1, 10, 2); rd_set(1, 1, 20, 2); tick(12);
    rd_set(0, 0, 0, 0);  rd_set(1, 0, 0, 0);  tick(4);

    // Move pointer to 1, then a zero-length request from 1 with 0 waiting
    rd_set(0, 1, 3, 1); tick(); rd_set(0, 0, 0, 0); tick(3);
    rd_set(0, 1, 7, 1); rd_set(1, 1, 9, 0); tick();
    rd_set(1, 0, 0, 0); tick(); rd_set(0, 0, 0, 0); tick(4);

    // Continuous writes from both requesters alongside a read burst
    wr_set(0, 1, 1, 64'hA); wr_set(1, 1, 2, 64'hB);
    rd_set(0, 1, 0, 4); tick(); rd_set(0, 0, 0, 0); tick(10);
    wr_set(0, 0, 0, 0); wr_set(1, 0, 0, 0); tick(3);

    // Reset in the second cycle of a long burst
    rd_set(0, 1, 16, 8); tick(); rd_set(0, 0, 0, 0); tick();
    rst = 1'b1; tick(); rst = 1'b0;
    rd_set(0, 1, 30, 2); rd_set(1, 1, 40, 2); tick();
    rd_set(0, 0, 0, 0);  rd_set(1, 0, 0, 0);  tick(6);

    // Randomized traffic with occasional resets
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        rd_set(i, $urandom_range(0, 3) == 0, $urandom_range(0, DEPTH - 1),
               ($urandom_range(0, 15) == 0) ? DEPTH : $urandom_range(0, 9));
        wr_set(i, $urandom_range(0, 1) == 1, $urandom_range(0, DEPTH - 1), {$urandom, $urandom});
      end
      rst = ($urandom_range(0, 599) == 0);
      tick();
    end
    rst = 1'b0; rd_req_valid = '0; wr_req_valid = '0;
    tick(80);
    chk("scoreboard_drained", sbq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
